vga_rect_writer: RTL
====================

# vga_rect_writer

Rectangle fill engine on the producer side of the frame buffer write port. It accepts one rectangle command at a time through a valid/ready handshake. It clips the rectangle to the visible screen and emits one 12-bit RGB pixel write per pixel in raster order. The game/board renderer drives it to paint tiles, borders and the background into the buffer that the VGA output stage displays.

## Interface
- HRES, default 800: visible width in pixels; x coordinates run 0..HRES-1.
- VRES, default 600: visible height in pixels; y coordinates run 0..VRES-1.
- X_W, default 11: width of x, w and wr_x.
- Y_W, default 10: width of y, h and wr_y.
- GATE_VBLNK, default 0: when 1, writes are issued only while vblnk=1.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  X_W  left edge.
- cmd_y  in  Y_W  top edge.
- cmd_w  in  X_W  width in pixels.
- cmd_h  in  Y_W  height in pixels.
- cmd_rgb  in  12  fill colour, 4:4:4.
- wr_en  out  1  pixel write valid.
- wr_x  out  X_W  pixel x.
- wr_y  out  Y_W  pixel y.
- wr_rgb  out  12  pixel colour.
- wr_ready  in  1  sink accepts the write this cycle.
- vblnk  in  1  vertical blanking from the VGA timing chain.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, CLIP, FILL, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_x, cmd_y, cmd_rgb, cmd_w and cmd_h, then go to CLIP.
- CLIP, 1 cycle
  - Compute x_end=min(cmd_x+cmd_w, HRES) and y_end=min(cmd_y+cmd_h, VRES). Use X_W+1 and Y_W+1 bit sums so the additions cannot overflow.
  - The rectangle is empty if cmd_w==0, cmd_h==0, cmd_x>=HRES or cmd_y>=VRES. Empty goes to DONE; otherwise load cur_x=cmd_x and cur_y=cmd_y and go to FILL.
- FILL
  - wr_en=1 when GATE_VBLNK==0 or vblnk==1. wr_x=cur_x, wr_y=cur_y, wr_rgb=latched colour.
  - A write completes on wr_en&&wr_ready. On completion:
    - if cur_x+1<x_end, then cur_x++;
    - else cur_x=cmd_x and cur_y++;
    - on the last pixel (cur_x==x_end-1 and cur_y==y_end-1), go to DONE.
  - While wr_en&&!wr_ready, wr_x, wr_y and wr_rgb hold stable.
  - When GATE_VBLNK=1, wr_en may drop when vblnk falls. The sink counts only cycles with wr_en&&wr_ready.
- DONE: done=1 for 1 cycle, then IDLE.
- Every pixel inside the clipped rectangle is written exactly once. No pixel outside it is ever written.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset: on the rst edge the state goes to IDLE and cur_x/cur_y clear to 0.
  - While rst=1: wr_en=0, busy=0, done=0, wr_x=0, wr_y=0, wr_rgb=0.
  - cmd_ready=1 from the first cycle after the rst edge.
- rst asserted mid-FILL aborts the command. wr_en=0 in the cycle after the rst edge, and no done pulse is produced.
- Accept in cycle T: CLIP at T+1, first wr_en at T+2 (subject to gating).
- Continuous stream: with wr_ready=1 and no gating, one pixel per cycle. A WxH rectangle therefore occupies T+2..T+1+W*H.
  - done is high the cycle after the last accepted write.
  - cmd_ready returns 1 one cycle after done.
- Empty rectangle: done at T+2, cmd_ready=1 at T+3, wr_en never asserted.
- Row wrap costs no bubble: the next pixel at (cmd_x, cur_y+1) follows immediately.
- Outputs are registered, except cmd_ready, busy and wr_en, which decode from state (wr_en also from vblnk).

## Test plan
- x=10, y=20, w=3, h=2, rgb=0xF00, wr_ready=1 -> writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21) on T+2..T+7, done at T+8, cmd_ready=1 at T+9.
- Clip with HRES=800, VRES=600: x=798, y=599, w=5, h=4, rgb=0x0F0 -> exactly two writes, (798,599) and (799,599), then done.
- Degenerate commands w=0, then x=800 w=4 h=4 -> zero writes; each gives done at T+2 and busy high for T+1..T+2.
- Backpressure: 4x4 at (0,0) with wr_ready toggling pseudo-randomly -> outputs stay stable while stalled; scoreboard sees 16 unique in-order pixels with no duplicates.
- GATE_VBLNK=1: 2x2 at (5,5), vblnk=0 for 10 cycles, then 1 -> no wr_en during vblnk=0; all 4 writes after vblnk rises.
- Reset mid-fill: 8x8 command, rst pulsed after 10 accepted writes -> wr_en=0 after the rst edge, no done, cmd_ready=1; a new 1x1 command then completes normally.

Source files
------------

// File: rtl/vga_rect_writer.sv
// Rectangle fill engine: accepts one rectangle command, clips it to the visible
// screen and streams one RGB pixel write per covered pixel in raster order.
module vga_rect_writer #(
    parameter int HRES       = 800,
    parameter int VRES       = 600,
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter bit GATE_VBLNK = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [X_W-1:0] cmd_x,
    input  logic [Y_W-1:0] cmd_y,
    input  logic [X_W-1:0] cmd_w,
    input  logic [Y_W-1:0] cmd_h,
    input  logic [11:0]    cmd_rgb,
    output logic           wr_en,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic [11:0]    wr_rgb,
    input  logic           wr_ready,
    input  logic           vblnk,
    output logic           busy,
    output logic           done
);

    localparam logic [X_W:0] HRES_L = (X_W+1)'(HRES);
    localparam logic [Y_W:0] VRES_L = (Y_W+1)'(VRES);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    state_t         state;
    logic [X_W-1:0] rect_x;
    logic [Y_W-1:0] rect_y;
    logic [X_W-1:0] rect_w;
    logic [Y_W-1:0] rect_h;
    logic [11:0]    rect_rgb;
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;

    logic           gate_ok;
    logic           fire;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic [X_W:0]   x_clip;
    logic [Y_W:0]   y_clip;
    logic           empty;
    logic [X_W:0]   x_nxt;
    logic [Y_W:0]   y_nxt;
    logic           row_end;
    logic           last_px;

    assign gate_ok   = !GATE_VBLNK || vblnk;
    assign cmd_ready = (state == IDLE);
    assign busy      = !rst && (state != IDLE);
    assign wr_en     = !rst && (state == FILL) && gate_ok;
    assign fire      = wr_en && wr_ready;

    assign wr_x   = cur_x;
    assign wr_y   = cur_y;
    assign wr_rgb = rect_rgb;

    // One extra bit on the sums keeps x+w / y+h from wrapping before the clip.
    assign x_sum  = {1'b0, rect_x} + {1'b0, rect_w};
    assign y_sum  = {1'b0, rect_y} + {1'b0, rect_h};
    assign x_clip = (x_sum > HRES_L) ? HRES_L : x_sum;
    assign y_clip = (y_sum > VRES_L) ? VRES_L : y_sum;
    assign empty  = (rect_w == '0) || (rect_h == '0) ||
                    ({1'b0, rect_x} >= HRES_L) || ({1'b0, rect_y} >= VRES_L);

    assign x_nxt   = {1'b0, cur_x} + 1'b1;
    assign y_nxt   = {1'b0, cur_y} + 1'b1;
    assign row_end = (x_nxt >= x_end);
    assign last_px = row_end && (y_nxt >= y_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_x    <= '0;
            cur_y    <= '0;
            rect_rgb <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rect_x   <= cmd_x;
                        rect_y   <= cmd_y;
                        rect_w   <= cmd_w;
                        rect_h   <= cmd_h;
                        rect_rgb <= cmd_rgb;
                        state    <= CLIP;
                    end
                end
                CLIP: begin
                    x_end <= x_clip;
                    y_end <= y_clip;
                    if (empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cur_x <= rect_x;
                        cur_y <= rect_y;
                        state <= FILL;
                    end
                end
                FILL: begin
                    // Position only advances on an accepted write, so a stall holds it.
                    if (fire) begin
                        if (last_px) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (row_end) begin
                            cur_x <= rect_x;
                            cur_y <= y_nxt[Y_W-1:0];
                        end else begin
                            cur_x <= x_nxt[X_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
